// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch prefetch stage.
package if_pkg;
   localparam int unsigned DEFAULT_XLEN = 32;
   localparam int unsigned INSTR_BYTES  = 4;
   localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_PC = '0;

   typedef struct packed {
      logic [DEFAULT_XLEN-1:0] pc;
      logic [DEFAULT_XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {pc, instr}; head is read combinationally.
// Flush wins over push/pop in the same cycle; caller guarantees no overflow.
module fetch_fifo
   import if_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  fetch_entry_t               push_dat,
   input  logic                       pop,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     count,
   output fetch_entry_t               head
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop_ok;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      pop_ok   = pop & (count_q != '0);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/if_prefetch_unit.sv
// Sequential instruction fetch into a prefetch queue; 2 cycles issue-to-out_valid.
// Issue stalls when queue plus in-flight read would exceed DEPTH; redirect flushes.
module if_prefetch_unit
   import if_pkg::*;
#(
   parameter int unsigned      XLEN     = DEFAULT_XLEN,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEFAULT_RESET_PC)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             halt,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic [XLEN-1:0]  imem_rdata,
   output logic             out_valid,
   output logic [XLEN-1:0]  out_instr,
   output logic [XLEN-1:0]  out_pc,
   input  logic             out_ready
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic             inflight_q, inflight_d;
   logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   occupancy;
   logic             issue, push, pop;
   fetch_entry_t     wr_entry, head;

   always_comb begin
      occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
      // Pops in this cycle are deliberately not credited, keeping the gate off the ready path.
      issue     = rst_n & ~redirect_valid & ~halt & (occupancy < (CNT_W+1)'(DEPTH));
      push      = inflight_q & ~redirect_valid;
      pop       = out_valid & out_ready;

      fetch_pc_d    = fetch_pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      end else if (issue) begin
         fetch_pc_d    = fetch_pc_q + XLEN'(INSTR_BYTES);
         inflight_pc_d = fetch_pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   assign wr_entry.pc    = inflight_pc_q;
   assign wr_entry.instr = imem_rdata;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat (wr_entry),
      .pop      (pop),
      .flush    (redirect_valid),
      .count    (count),
      .head     (head)
   );

   assign imem_req  = issue;
   assign imem_addr = fetch_pc_q;
   assign out_valid = (count != '0);
   assign out_pc    = head.pc;
   assign out_instr = head.instr;
endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized bench for if_prefetch_unit against a queue-based reference model.
module tb_if_prefetch_unit;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        halt = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready = 1'b0;

   if_prefetch_unit #(
      .XLEN     (32),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .halt           (halt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_ready      (out_ready)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_req = 0;

   // Reference model: expected queue contents as a list of PCs, plus the fetch pointer.
   logic [31:0] m_pc;
   bit          m_infl;
   logic [31:0] m_infl_pc;
   logic [31:0] m_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc      = RESET_PC;
      m_infl    = 1'b0;
      m_infl_pc = '0;
      m_q.delete();
   endtask

   // One clock cycle: drive, check at negedge, advance model at posedge, then act as memory.
   task automatic cycle(input bit rv, input logic [31:0] rpc, input bit h, input bit rdy);
      bit          exp_issue;
      bit          req;
      logic [31:0] addr;
      logic [31:0] dummy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt           = h;
      out_ready      = rdy;
      @(negedge clk);
      exp_issue = !rv && !h && ((m_q.size() + int'(m_infl)) < DEPTH);
      check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_issue});
      if (exp_issue) check_eq("imem_addr", imem_addr, m_pc);
      check_eq("out_valid", {31'b0, out_valid}, {31'b0, (m_q.size() != 0)});
      if (m_q.size() != 0) begin
         check_eq("out_pc", out_pc, m_q[0]);
         check_eq("out_instr", out_instr, mem_word(m_q[0]));
      end
      req  = imem_req;
      addr = imem_addr;
      if (req) n_req++;
      @(posedge clk);
      if (rv) begin
         m_q.delete();
         m_infl = 1'b0;
         m_pc   = {rpc[31:2], 2'b00};
      end else begin
         if (rdy && m_q.size() != 0) dummy = m_q.pop_front();
         if (m_infl) m_q.push_back(m_infl_pc);
         m_infl = exp_issue;
         if (exp_issue) begin
            m_infl_pc = m_pc;
            m_pc      = m_pc + 32'd4;
         end
      end
      #1;
      imem_rdata = req ? mem_word(addr) : $urandom;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #10;
      check_eq("rst_imem_req", {31'b0, imem_req}, 32'd0);
      check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("rst_out_instr", out_instr, 32'd0);
      check_eq("rst_out_pc", out_pc, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();

      repeat (20) cycle(1'b0, '0, 1'b0, 1'b1);

      // Decode stalled after a flush: exactly DEPTH reads go out, then all drain in order.
      cycle(1'b1, 32'h400, 1'b0, 1'b1);
      n_req = 0;
      repeat (12) cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("stall_req_count", 32'(n_req), 32'(DEPTH));
      repeat (10) cycle(1'b0, '0, 1'b0, 1'b1);

      // Redirect colliding with a response and a pop, then an unaligned target.
      cycle(1'b1, 32'h100, 1'b0, 1'b1);
      repeat (6) cycle(1'b0, '0, 1'b0, 1'b1);
      cycle(1'b1, 32'h203, 1'b0, 1'b1);
      repeat (6) cycle(1'b0, '0, 1'b0, 1'b1);

      n_req = 0;
      repeat (5) cycle(1'b0, '0, 1'b1, 1'b1);
      check_eq("halt_req_count", 32'(n_req), 32'd0);
      repeat (5) cycle(1'b0, '0, 1'b0, 1'b1);

      cycle(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
      repeat (8) cycle(1'b0, '0, 1'b0, 1'b1);

      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 19) == 0), $urandom,
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
      end

      // Asynchronous reset in the middle of a cycle with data queued.
      repeat (6) cycle(1'b0, '0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("midrst_imem_req", {31'b0, imem_req}, 32'd0);
      check_eq("midrst_out_pc", out_pc, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      repeat (12) cycle(1'b0, '0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
